// File: rtl/fpu_pkg.sv
// Shared types and defaults for the fsub result queue.
// fpu_result_t describes one queued result at the default tag width.
package fpu_pkg;

    localparam int FPU_DEPTH   = 4;
    localparam int FPU_TAG_W   = 5;
    localparam int OVF_CNT_MAX = 255;

    typedef struct packed {
        logic [31:0]          y;
        logic                 ovf;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_result_t;

    // Overflow counter sticks at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'(OVF_CNT_MAX)) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered circular FIFO: storage plus wrap-around read/write pointers.
// Push is refused while full, even if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Qualify against current state only, so full+pop never admits a write.
    assign do_push = wr_en_i && !full_o;
    assign do_pop  = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the output mask below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fpu_result_queue.sv
// Result queue between the fsub stage and writeback, with a sticky
// overflow flag and a saturating count of accepted overflowing results.
module fpu_result_queue
    import fpu_pkg::*;
#(
    parameter int DEPTH = FPU_DEPTH,
    parameter int TAG_W = FPU_TAG_W,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_y,
    input  logic             in_ovf,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic [CW-1:0]    count,
    output logic             flag_ovf,
    input  logic             flag_clr,
    output logic [7:0]       ovf_cnt
);

    localparam int W = 32 + 1 + TAG_W;

    logic [W-1:0] wdata, rdata;
    logic         full, empty;
    logic         push, ovf_hit;
    logic         flag_q, flag_d;
    logic [7:0]   cnt_q, cnt_d;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign wdata     = {in_y, in_ovf, in_tag};

    sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en_i (in_valid),
        .rd_en_i (out_ready),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign {out_y, out_ovf, out_tag} = rdata;

    assign ovf_hit = push && in_ovf;

    // A clear coinciding with a new overflow still records that overflow.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (ovf_hit)       flag_d = 1'b1;
        else if (flag_clr) flag_d = 1'b0;
        if (flag_clr)      cnt_d  = {7'd0, ovf_hit};
        else if (ovf_hit)  cnt_d  = sat_inc8(cnt_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag_q <= 1'b0;
            cnt_q  <= 8'd0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
        end
    end

    assign flag_ovf = flag_q;
    assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_fpu_result_queue.sv
// Scoreboard bench for fpu_result_queue: directed vectors plus a cycle model.
module tb_fpu_result_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 5;
    localparam int CW    = 3;

    logic             clk, rstn;
    logic             in_valid, in_ready, in_ovf;
    logic [31:0]      in_y;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid, out_ready, out_ovf;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;
    logic [CW-1:0]    count;
    logic             flag_ovf, flag_clr;
    logic [7:0]       ovf_cnt;

    fpu_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_ovf(in_ovf), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_ovf(out_ovf), .out_tag(out_tag),
        .count(count), .flag_ovf(flag_ovf), .flag_clr(flag_clr),
        .ovf_cnt(ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nmis = 0;
    fpu_result_t sb[$];
    int          mcount = 0;
    logic        mflag = 1'b0;
    logic [7:0]  mcnt = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle model: checks state, then predicts the next edge and queues accepted pushes.
    always @(negedge clk) begin
        if (!rstn) begin
            mcount = 0;
            mflag  = 1'b0;
            mcnt   = 8'd0;
            sb.delete();
        end else begin
            logic mpush, mpop, hit;
            fpu_result_t e;
            chk("count", 32'(count), 32'(mcount));
            chk("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(mcount != 0));
            chk("flag_ovf", 32'(flag_ovf), 32'(mflag));
            chk("ovf_cnt", 32'(ovf_cnt), 32'(mcnt));
            if (mcount == 0) begin
                chk("empty_y", out_y, 32'h0);
                chk("empty_ovf_tag", 32'({out_ovf, out_tag}), 32'h0);
            end
            mpush = in_valid && (mcount != DEPTH);
            mpop  = out_ready && (mcount != 0);
            hit   = mpush && in_ovf;
            if (mpush) begin
                e.y = in_y; e.ovf = in_ovf; e.tag = in_tag;
                sb.push_back(e);
            end
            if (hit) mflag = 1'b1;
            else if (flag_clr) mflag = 1'b0;
            if (flag_clr) mcnt = {7'd0, hit};
            else if (hit && mcnt != 8'd255) mcnt = mcnt + 8'd1;
            mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
        end
    end

    // Monitor: every consumed head entry must match the oldest expected one.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL pop_unexpected: got y=%h expected no entry", out_y);
            end else begin
                fpu_result_t e;
                e = sb.pop_front();
                chk("pop_y", out_y, e.y);
                chk("pop_ovf_tag", 32'({out_ovf, out_tag}), 32'({e.ovf, e.tag}));
            end
        end
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_y = '0; in_ovf = 1'b0; in_tag = '0;
        out_ready = 1'b0; flag_clr = 1'b0;
        repeat (2) step();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flag", 32'(flag_ovf), 32'd0);
        chk("rst_cnt", 32'(ovf_cnt), 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        rstn = 1'b1;

        // single push: visible exactly one edge later
        in_valid = 1'b1; in_y = 32'h3F80_0000; in_tag = 5'd3;
        step();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_y", out_y, 32'h3F80_0000);
        chk("single_tag", 32'(out_tag), 32'd3);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_drained", 32'(count), 32'd0);

        // fill to full, reject while full, full+pop still rejects
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_y = 32'h4000_0000 + 32'(i); in_tag = 5'(i);
            step();
        end
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        in_y = 32'h4000_0005; in_tag = 5'd5;
        step();
        chk("full_reject", 32'(count), 32'd4);
        in_y = 32'h4000_0006; in_tag = 5'd6; out_ready = 1'b1;
        step();
        chk("full_pop_no_push", 32'(count), 32'd3);
        in_y = 32'h4000_0007; in_tag = 5'd7; out_ready = 1'b0;
        step();
        chk("freed_slot_push", 32'(count), 32'd4);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("fill_drained", 32'(count), 32'd0);

        // steady push+pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_y = 32'hA000_0000 + 32'(i); in_tag = 5'(i + 20);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_y = 32'h5000_0000 + 32'(i * 3); in_tag = 5'(i);
            step();
            chk("stream_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        repeat (2) step();
        out_ready = 1'b0;
        chk("stream_drained", 32'(count), 32'd0);

        // overflow flag and counter, clear colliding with a new overflow
        in_valid = 1'b1; in_y = 32'h7F80_0000; in_ovf = 1'b1; in_tag = 5'd9;
        step();
        in_valid = 1'b0;
        chk("ovf_flag_set", 32'(flag_ovf), 32'd1);
        chk("ovf_cnt_1", 32'(ovf_cnt), 32'd1);
        in_valid = 1'b1; in_y = 32'hFF80_0000;
        step();
        chk("ovf_cnt_2", 32'(ovf_cnt), 32'd2);
        flag_clr = 1'b1; in_y = 32'h7F80_0000; in_tag = 5'd10;
        step();
        in_valid = 1'b0;
        chk("clr_vs_set_flag", 32'(flag_ovf), 32'd1);
        chk("clr_vs_set_cnt", 32'(ovf_cnt), 32'd1);
        step();
        flag_clr = 1'b0;
        chk("clr_flag", 32'(flag_ovf), 32'd0);
        chk("clr_cnt", 32'(ovf_cnt), 32'd0);
        out_ready = 1'b1;
        repeat (3) step();

        // counter saturation
        in_valid = 1'b1; in_ovf = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_y = 32'h7F80_0000 | 32'(i); in_tag = 5'(i);
            step();
        end
        in_valid = 1'b0; in_ovf = 1'b0;
        step();
        out_ready = 1'b0;
        chk("sat_cnt", 32'(ovf_cnt), 32'd255);
        chk("sat_flag", 32'(flag_ovf), 32'd1);

        // asynchronous reset mid-stream at count=3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_y = 32'hC000_0000 + 32'(i); in_tag = 5'(i + 1);
            step();
        end
        chk("pre_rst_count", 32'(count), 32'd3);
        in_y = 32'hC000_0003; rstn = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_flag", 32'(flag_ovf), 32'd0);
        chk("arst_cnt", 32'(ovf_cnt), 32'd0);
        step();
        in_y = 32'h1234_5678; in_tag = 5'd17; rstn = 1'b1;
        step();
        in_valid = 1'b0;
        chk("first_push_count", 32'(count), 32'd1);
        chk("first_push_y", out_y, 32'h1234_5678);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("final_count", 32'(count), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/fpu_result_queue.md
FPU_RESULT_QUEUE -- requirements
Module: fpu_result_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of result entries; power of two, at least 2.
REQ-002 Parameter: TAG_W, 5, destination-register tag width.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rstn  input  1  reset, asynchronous and active-low.
REQ-005 Port: in_valid  input  1  the fsub stage presents a result.
REQ-006 Port: in_ready  output  1  the queue accepts a result this cycle.
REQ-007 Port: in_y  input  32  fsub result word y.
REQ-008 Port: in_ovf  input  1  fsub overflow flag ovf.
REQ-009 Port: in_tag  input  TAG_W  destination tag travelling with the result.
REQ-010 Port: out_valid  output  1  the head entry is available for writeback.
REQ-011 Port: out_ready  input  1  writeback consumes the head entry this cycle.
REQ-012 Port: out_y / out_ovf / out_tag  output  32 / 1 / TAG_W  head-entry fields.
REQ-013 Port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 Port: flag_ovf  output  1  sticky overflow status.
REQ-015 Port: flag_clr  input  1  clears flag_ovf.
REQ-016 Port: ovf_cnt  output  8  saturating count of accepted overflowing results.

Function
REQ-017 The block SHALL be a registered FIFO of {y, ovf, tag} with circular read and write pointers that wrap modulo DEPTH.
REQ-018 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count != DEPTH). It SHALL be combinational from state only, never from in_valid or out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_y, out_ovf and out_tag SHALL be driven from the head-entry registers.
REQ-021 The block SHALL have no bypass path: a result pushed into an empty queue at edge N SHALL appear at the output with out_valid=1 after edge N, giving a latency of 1 cycle.
REQ-022 On a simultaneous push and pop with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full, a push SHALL NOT occur even if a pop occurs in the same cycle; the freed slot SHALL become writable in the next cycle.
REQ-024 When out_valid=1 and out_ready=0, the output fields SHALL hold stable.
REQ-025 flag_ovf SHALL set on any push with in_ovf=1 and SHALL clear on flag_clr; if both occur in the same cycle, set SHALL win.
REQ-026 ovf_cnt SHALL increment on each push with in_ovf=1, SHALL saturate at 255, and SHALL clear on flag_clr; if both occur in the same cycle, the result SHALL be 1.
REQ-027 Data SHALL pass through bit-exact; the queue SHALL NOT inspect the exponent or mantissa of in_y.

Reset
REQ-028 Assertion of rstn SHALL immediately force the pointers to 0, count=0, out_valid=0, in_ready=1, flag_ovf=0 and ovf_cnt=0, including during an in-flight push or pop.
REQ-029 Storage contents need not reset; out_y, out_ovf and out_tag SHALL read 0 while count=0.
REQ-030 The first push SHALL be accepted on the first rising clk edge after rstn deasserts.

Structure
REQ-031 Package fpu_pkg SHALL hold typedef fpu_result_t {y[31:0], ovf, tag} and the default constants for DEPTH and TAG_W.
REQ-032 The storage and pointer logic SHALL be one sub-module, sync_fifo, parameterised by width and depth. The flag logic and the counter SHALL live in fpu_result_queue.

Verification
REQ-033 Single push with y=0x3F800000, tag=3 into an empty queue SHALL produce out_valid=1 one cycle later with out_y=0x3F800000 and out_tag=3.
REQ-034 Five back-to-back pushes with out_ready=0 and DEPTH=4 SHALL give in_ready=0 after the 4th push and count=4; the 5th value SHALL be rejected and pops SHALL return entries 1 to 4 in order.
REQ-035 A continuous push and pop at count=2 for 20 cycles SHALL keep count=2, and outputs SHALL match inputs in order across pointer wrap.
REQ-036 A push of y=0x7F800000 with ovf=1 SHALL set flag_ovf=1 and ovf_cnt=1. flag_clr asserted with a further ovf=1 push in the same cycle SHALL give flag_ovf=1 and ovf_cnt=1.
REQ-037 300 ovf=1 pushes with a free-running pop SHALL leave ovf_cnt=255.
REQ-038 rstn driven low mid-stream at count=3 SHALL give count=0, out_valid=0, in_ready=1 and flag_ovf=0 before the next clk edge.
